mdu_iter: RTL

//  Parametrised RV32M/RV64M multiply/divide unit with a valid/ready handshake.

---
 rtl/mdu_iter.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/mdu_iter.sv
// Iterative RV32M/RV64M multiply/divide unit: pipelined-latency multiply, restoring radix-2 divide.
// Optional macro MDU_DIV_EARLY_OUT_EN: divide-by-zero and signed overflow complete in one cycle.
module mdu_iter #(
  parameter int XLEN        = 32,
  parameter int MUL_LATENCY = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);
  localparam int CW = $clog2(XLEN + MUL_LATENCY + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t          r_state;
  logic            r_in_ready, r_out_valid, r_busy;
  logic [XLEN-1:0] r_result;
  logic [2:0]      r_op;
  logic [XLEN-1:0] r_a, r_b, r_q, r_rem, r_d;
  logic            r_negq, r_negr, r_div0;
  logic [CW-1:0]   r_cnt;

  function automatic logic [XLEN-1:0] f_mul(input logic [2:0] fop,
                                           input logic [XLEN-1:0] x, input logic [XLEN-1:0] y);
    logic sx, sy;
    logic [2*XLEN-1:0] ex, ey, p;
    sx = (fop[1:0] == 2'd1) || (fop[1:0] == 2'd2);
    sy = (fop[1:0] == 2'd1);
    ex = {{XLEN{sx & x[XLEN-1]}}, x};
    ey = {{XLEN{sy & y[XLEN-1]}}, y};
    p  = ex * ey;
    return (fop[1:0] == 2'd0) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  // Divide-by-zero or MIN/-1 results; x is the original dividend.
  function automatic logic [XLEN-1:0] f_special(input logic [2:0] fop,
                                               input logic [XLEN-1:0] x, input logic div0);
    if (div0) return fop[1] ? x : '1;
    return fop[1] ? '0 : x;
  endfunction

  logic            w_sgn, w_an, w_bn, w_div0;
  logic [XLEN-1:0] w_amag, w_bmag;
  logic [XLEN:0]   w_sh, w_sub;
  logic            w_qbit;
  logic [XLEN-1:0] w_rem_n, w_q_n, w_qs, w_rs, w_dres;

  assign w_sgn  = !op[0];
  assign w_an   = w_sgn & a[XLEN-1];
  assign w_bn   = w_sgn & b[XLEN-1];
  assign w_div0 = (b == '0);
  assign w_amag = w_an ? -a : a;
  assign w_bmag = w_bn ? -b : b;

`ifdef MDU_DIV_EARLY_OUT_EN
  logic w_ovf;
  assign w_ovf = w_sgn && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
`endif

  // One restoring step: shift next dividend bit into the partial remainder, trial-subtract.
  assign w_sh    = {r_rem, r_q[XLEN-1]};
  assign w_sub   = w_sh - {1'b0, r_d};
  assign w_qbit  = !w_sub[XLEN];
  assign w_rem_n = w_qbit ? w_sub[XLEN-1:0] : w_sh[XLEN-1:0];
  assign w_q_n   = {r_q[XLEN-2:0], w_qbit};
  assign w_qs    = r_negq ? -w_q_n : w_q_n;
  assign w_rs    = r_negr ? -w_rem_n : w_rem_n;
  assign w_dres  = r_div0 ? f_special(r_op, r_a, 1'b1) : (r_op[1] ? w_rs : w_qs);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_result    <= '0;
      r_cnt       <= '0;
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_q         <= '0;
      r_rem       <= '0;
      r_d         <= '0;
      r_negq      <= 1'b0;
      r_negr      <= 1'b0;
      r_div0      <= 1'b0;
    end else if (flush) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_result    <= '0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_op       <= op;
          r_a        <= a;
          r_b        <= b;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b1;
          if (!op[2]) begin
            if (MUL_LATENCY == 1) begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
              r_result    <= f_mul(op, a, b);
            end else begin
              r_state <= S_MUL;
              r_cnt   <= CW'(1);
            end
          end else begin
            r_q    <= w_amag;
            r_rem  <= '0;
            r_d    <= w_bmag;
            r_negq <= w_an ^ w_bn;
            r_negr <= w_an;
            r_div0 <= w_div0;
            r_cnt  <= '0;
`ifdef MDU_DIV_EARLY_OUT_EN
            if (w_div0 || w_ovf) begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
              r_result    <= f_special(op, a, w_div0);
            end else begin
              r_state <= S_DIV;
            end
`else
            r_state <= S_DIV;
`endif
          end
        end
        S_MUL: begin
          if (r_cnt == CW'(MUL_LATENCY-1)) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
            r_result    <= f_mul(r_op, r_a, r_b);
            r_cnt       <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        // XLEN iterations; the last one also applies the sign fixup on its way to DONE.
        S_DIV: begin
          r_q   <= w_q_n;
          r_rem <= w_rem_n;
          if (r_cnt == CW'(XLEN-1)) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
            r_result    <= w_dres;
            r_cnt       <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: if (out_ready) begin
          r_state     <= S_IDLE;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
          r_result    <= '0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign busy      = r_busy;
endmodule
